// File: rtl/data_bus_unit.sv
// data_bus_unit: CPU data-side bus interface with address decode and read mux.
// Routes each access to the internal byte-writable DMEM, the output peripheral
// or the read-only pattern-matching peripheral. Reads return combinationally.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   reset    - synchronous, active-low reset (suppresses writes, keeps DMEM)
//   daddr    - CPU data byte address
//   dwdata   - CPU write data
//   dwe      - CPU byte write enables, bit i -> dwdata[8i+7:8i]
//   drdata   - read data to CPU (combinational)
//   daddr2   - address pass-through to output peripheral
//   dwdata2  - write data pass-through to output peripheral
//   dwe2     - byte enables to output peripheral (only when OUT selected)
//   drdata2  - read data from output peripheral
//   drdata3  - read data from pattern-matching peripheral
//   buserr   - sticky bus error flag (only when BIU_BUSERR_EN is defined)
//
// Optional feature macro: BIU_BUSERR_EN
// DMEM_WORDS must be a power of two, at least 2.

module data_bus_unit #(
    parameter int unsigned DMEM_WORDS = 1024,
    parameter logic [31:0] OUT_BASE   = 32'h0000_4000,
    parameter logic [31:0] PM_BASE    = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dwe,
    output logic [31:0] drdata,
    output logic [31:0] daddr2,
    output logic [31:0] dwdata2,
    output logic [3:0]  dwe2,
    input  logic [31:0] drdata2,
    input  logic [31:0] drdata3
`ifdef BIU_BUSERR_EN
    ,
    output logic        buserr
`endif
);

    localparam int unsigned IDX_W      = $clog2(DMEM_WORDS);
    localparam int unsigned REGION_LSB = 14;

    logic [31:0]      mem_q [DMEM_WORDS];
    logic [IDX_W-1:0] widx_c;
    logic             dmem_sel_c;
    logic             out_sel_c;
    logic             pm_sel_c;
    logic             unmapped_c;

    // Address decode: exactly one of the four selects is active per access.
    always_comb begin
        dmem_sel_c = 1'b0;
        out_sel_c  = 1'b0;
        pm_sel_c   = 1'b0;
        unmapped_c = 1'b0;
        widx_c     = daddr[IDX_W+1:2];
        if (daddr[31:IDX_W+2] == '0) begin
            dmem_sel_c = 1'b1;
        end else if (daddr[31:REGION_LSB] == OUT_BASE[31:REGION_LSB]) begin
            out_sel_c = 1'b1;
        end else if (daddr[31:REGION_LSB] == PM_BASE[31:REGION_LSB]) begin
            pm_sel_c = 1'b1;
        end else begin
            unmapped_c = 1'b1;
        end
    end

    // Read mux; DMEM read sees pre-edge contents, giving read-before-write.
    always_comb begin
        drdata = 32'h0;
        if (dmem_sel_c) begin
            drdata = mem_q[widx_c];
        end else if (out_sel_c) begin
            drdata = drdata2;
        end else if (pm_sel_c) begin
            drdata = drdata3;
        end
    end

    // Peripheral pass-through; enables gated so reset or other regions never strobe OUT.
    always_comb begin
        daddr2  = daddr;
        dwdata2 = dwdata;
        dwe2    = (out_sel_c && reset) ? dwe : 4'b0000;
    end

    // Byte-lane DMEM write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (reset && dmem_sel_c) begin
            for (int i = 0; i < 4; i++) begin
                if (dwe[i]) begin
                    mem_q[widx_c][8*i +: 8] <= dwdata[8*i +: 8];
                end
            end
        end
    end

`ifdef BIU_BUSERR_EN
    logic buserr_q;
    logic buserr_d;

    // Sticky error on unmapped access or any write into the read-only PM region.
    always_comb begin
        buserr_d = buserr_q;
        if (unmapped_c || (pm_sel_c && (dwe != 4'b0000))) begin
            buserr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            buserr_q <= 1'b0;
        end else begin
            buserr_q <= buserr_d;
        end
    end

    assign buserr = buserr_q;
`endif

endmodule

// File: tb/tb_data_bus_unit.sv
// Self-checking bench for data_bus_unit: directed steps followed by random
// accesses, all checked against a region-based behavioural model.

module tb_data_bus_unit;

    logic        clk;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dwe;
    logic [31:0] drdata;
    logic [31:0] daddr2;
    logic [31:0] dwdata2;
    logic [3:0]  dwe2;
    logic [31:0] drdata2;
    logic [31:0] drdata3;
`ifdef BIU_BUSERR_EN
    logic        buserr;
`endif

    data_bus_unit dut (
        .clk     (clk),
        .reset   (reset),
        .daddr   (daddr),
        .dwdata  (dwdata),
        .dwe     (dwe),
        .drdata  (drdata),
        .daddr2  (daddr2),
        .dwdata2 (dwdata2),
        .dwe2    (dwe2),
        .drdata2 (drdata2),
        .drdata3 (drdata3)
`ifdef BIU_BUSERR_EN
        ,
        .buserr  (buserr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: 4 KB byte-addressed memory as words, plus error flag.
    logic [31:0] mem_m [1024];
    bit          err_m;
    bit          err_known;
    int          n_assert;
    int          n_fail;
    logic [31:0] last_rd;
    logic [3:0]  last_we2;

    function automatic bit in_dmem(input logic [31:0] a);
        return a < 32'h0000_1000;
    endfunction

    function automatic bit in_out(input logic [31:0] a);
        return (a >= 32'h0000_4000) && (a < 32'h0000_8000);
    endfunction

    function automatic bit in_pm(input logic [31:0] a);
        return (a >= 32'h0000_8000) && (a < 32'h0000_C000);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a,
                                               input logic [31:0] p2,
                                               input logic [31:0] p3);
        if (in_dmem(a)) return mem_m[a / 4];
        if (in_out(a))  return p2;
        if (in_pm(a))   return p3;
        return 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive after negedge, check mid-low-phase, update model at posedge.
    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                        input logic rst, input logic [31:0] p2, input logic [31:0] p3);
        logic [31:0] w;
        reset   = rst;
        daddr   = a;
        dwdata  = wd;
        dwe     = we;
        drdata2 = p2;
        drdata3 = p3;
        #2;
        last_rd  = drdata;
        last_we2 = dwe2;
        chk("drdata",  drdata,  model_read(a, p2, p3));
        chk("daddr2",  daddr2,  a);
        chk("dwdata2", dwdata2, wd);
        chk("dwe2",    32'(dwe2), (rst && in_out(a)) ? 32'(we) : 32'h0);
`ifdef BIU_BUSERR_EN
        if (err_known) chk("buserr", 32'(buserr), 32'(err_m));
`endif
        @(posedge clk);
        if (rst && in_dmem(a)) begin
            w = mem_m[a / 4];
            for (int i = 0; i < 4; i++)
                if (we[i]) w[8*i +: 8] = wd[8*i +: 8];
            mem_m[a / 4] = w;
        end
        if (!rst) begin
            err_m     = 1'b0;
            err_known = 1'b1;
        end else if (!(in_dmem(a) || in_out(a) || in_pm(a)) || (in_pm(a) && we != 4'h0)) begin
            err_m = 1'b1;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0, 1:    return 32'($urandom_range(0, 32'h0FFF));
            2:       return 32'h0000_4000 + 32'($urandom_range(0, 32'h3FFF));
            3:       return 32'h0000_8000 + 32'($urandom_range(0, 32'h3FFF));
            4:       return 32'h0000_1000 + 32'($urandom_range(0, 32'h2FFF));
            default: return 32'($urandom) | 32'h0001_0000;
        endcase
    endfunction

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        err_m     = 1'b0;
        err_known = 1'b0;
        for (int i = 0; i < 1024; i++) mem_m[i] = 32'h0;

        // Reset state: pass-through follows inputs, no OUT strobe.
        step(32'h0000_4000, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0, 32'h0);
        chk("rst_dwe2", 32'(last_we2), 32'h0);

        // Fill DMEM so every later read has a defined expectation.
        for (int i = 0; i < 1024; i++)
            step(32'(i * 4), 32'($urandom), 4'hF, 1'b1, 32'h0, 32'h0);

        // Full-word write then read.
        step(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0, 32'h0);
        step(32'h10, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0);
        chk("tp_word", last_rd, 32'hDEAD_BEEF);

        // Byte lanes, including unaligned read of the same word.
        step(32'h20, 32'h1122_3344, 4'hF, 1'b1, 32'h0, 32'h0);
        step(32'h20, 32'hAA55_AA55, 4'b0100, 1'b1, 32'h0, 32'h0);
        chk("tp_rbw", last_rd, 32'h1122_3344);
        step(32'h20, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0);
        chk("tp_lane", last_rd, 32'h1155_3344);
        step(32'h22, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0);
        chk("tp_lane_unal", last_rd, 32'h1155_3344);

        // Write suppression during reset.
        step(32'h30, 32'h1234_5678, 4'hF, 1'b1, 32'h0, 32'h0);
        step(32'h30, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, 32'h0);
        chk("tp_rst_we2", 32'(last_we2), 32'h0);
        step(32'h30, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0);
        chk("tp_rst_keep", last_rd, 32'h1234_5678);

        // Output peripheral routing leaves DMEM word 0 alone.
        step(32'h0000_4000, 32'h0000_0041, 4'h1, 1'b1, 32'h0, 32'h0);
        chk("tp_out_we2", 32'(last_we2), 32'h1);
        step(32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0);

        // Read mux across regions.
        step(32'h0000_4004, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 32'hCAFE_F00D);
        chk("tp_mux_out", last_rd, 32'h1234_5678);
        step(32'h0000_8000, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 32'hCAFE_F00D);
        chk("tp_mux_pm", last_rd, 32'hCAFE_F00D);
        step(32'h0001_0000, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 32'hCAFE_F00D);
        chk("tp_mux_unm", last_rd, 32'h0);

        // Sticky error: clear, PM write, hold, then reset clears.
        step(32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0);
        step(32'h0, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0);
        step(32'h0000_8000, 32'h1, 4'hF, 1'b1, 32'h0, 32'h0);
        step(32'h4, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0);
        step(32'h8, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0);
        step(32'hC, 32'h0, 4'h0, 1'b1, 32'h0, 32'h0);

        // Random traffic with occasional reset.
        for (int n = 0; n < 3000; n++)
            step(rand_addr(), 32'($urandom), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 19) != 0), 32'($urandom), 32'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_bus_unit.md
Name: data_bus_unit

Overview:
- Data-side bus interface for the single-cycle CPU: decodes the CPU data address and routes each access to one of three targets.
- Targets: an internal byte-writable data memory (DMEM), the output peripheral port, or the read-only pattern-matching peripheral input.
- Returns read data to the CPU combinationally within the same cycle.
- Sits between cpu and the outperiph / pattern-matching peripheral; replaces the separate biu + dmem pair.

Parameters:
- DMEM_WORDS, 1024, number of 32-bit DMEM words (4 KB, base 0x0000_0000); must be a power of two.
- OUT_BASE, 32'h0000_4000, base of output-peripheral region (16 KB region, selected by daddr[31:14]).
- PM_BASE, 32'h0000_8000, base of pattern-matching read region (16 KB region, selected by daddr[31:14]).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- daddr  input  32  CPU data byte address.
- dwdata  input  32  CPU write data.
- dwe  input  4  CPU byte write enables; bit i enables byte lane i = dwdata[8i+7:8i].
- drdata  output  32  read data to CPU.
- daddr2  output  32  address to output peripheral.
- dwdata2  output  32  write data to output peripheral.
- dwe2  output  4  byte write enables to output peripheral.
- drdata2  input  32  read data from output peripheral.
- drdata3  input  32  read data from pattern-matching peripheral.

Behaviour:
- Decode is combinational from daddr, with exactly one selection per access:
  - DMEM: daddr < DMEM_WORDS*4.
  - OUT: daddr[31:14] == OUT_BASE[31:14].
  - PM: daddr[31:14] == PM_BASE[31:14].
  - Any other address is unmapped.
- Word index is daddr[31:2]; daddr[1:0] are ignored by every target. No misalignment handling; lanes come straight from dwe.
- Read mux, combinational, zero latency, valid in the same cycle as daddr:
  - DMEM selected -> mem[daddr[log2(DMEM_WORDS)+1:2]].
  - OUT selected -> drdata2.
  - PM selected -> drdata3.
  - Unmapped -> 32'h0.
- DMEM write: on rising clk, when reset==1 and DMEM is selected, each byte lane with dwe[i]==1 is updated. Lanes with dwe[i]==0 keep their value.
- New DMEM data is visible on drdata from the cycle after the write edge. During the write cycle itself, drdata shows the old contents.
- Reset asserted (reset==0): all DMEM writes are suppressed; DMEM contents are not cleared; reads still function.
- Peripheral pass-through (combinational):
  - daddr2 = daddr and dwdata2 = dwdata, always.
  - dwe2 = dwe when OUT is selected and reset==1; otherwise 4'b0000.
- Writes to the PM region or to unmapped addresses are dropped (no side effects).
- dwe == 0 is a pure read; there are no side effects on reads.
- Simultaneous read/write to the same DMEM word is read-before-write, as stated above.
- Only one access per cycle; no handshake, no stalls, no internal FSM.
- Reset values: drdata, daddr2 and dwdata2 follow the inputs; dwe2 = 0 during reset.

Optional Feature:
- Macro: BIU_BUSERR_EN.
- Defined:
  - Adds output port buserr (1 bit, registered).
  - On rising clk with reset==1, buserr is set to 1 if the current access is unmapped, or is a write (dwe != 0) to the PM region.
  - It is sticky until reset; reset==0 clears it to 0.
- Not defined: no buserr port and no extra logic; behaviour is otherwise identical.

Test Plan:
- Full-word write then read: reset released; write 0xDEADBEEF to 0x0000_0010 with dwe=4'hF; next cycle read 0x10 -> drdata = 0xDEADBEEF.
- Byte lanes: preload 0x11223344 at 0x20; write dwe=4'b0100, dwdata=0xAA55AA55 -> read 0x20 = 0x11553344; read 0x22 also = 0x11553344.
- Reset write suppression: with reset=0, write 0xFFFFFFFF to 0x30 -> after reset=1, read 0x30 returns its prior value; dwe2 stays 0 during reset.
- Output peripheral routing: write 0x00000041 to 0x4000 with dwe=4'h1 -> dwe2 = 4'h1, dwdata2 = 0x41, daddr2 = 0x4000; DMEM word 0 unchanged.
- Read mux: drdata2 = 0x12345678 and drdata3 = 0xCAFEF00D -> reading 0x4004 gives 0x12345678, 0x8000 gives 0xCAFEF00D, 0x00010000 gives 0.
- BIU_BUSERR_EN: write to 0x8000 -> buserr = 1 next cycle and stays 1; reset=0 for one edge -> buserr = 0.
